interval_timer_ctrl: RTL and testbench

- Controller that sequences a WIDTH-bit synchronous up-counter into a programmable interval timer, with one-shot and periodic modes, a prescaler, pause/resume and a sticky interrupt.
- The count datapath is WIDTH/4 cascaded 4-bit enable-chained slices; the block generates their count enable, detects terminal count, and reloads or stops.
- Sits between the control/status register block and the counter datapath.

---
 rtl/interval_timer_ctrl_if.sv | 35 +++
 rtl/interval_timer_ctrl.sv | 145 ++++++++++++++
 tb/tb_interval_timer_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/interval_timer_ctrl_if.sv
// Interval timer control/status bundle.
// master: the register block side; it drives start/stop/hold/mode_periodic/
//         period/prescale/irq_ack and observes count/tick/expired/irq/busy/
//         state/overrun.
// slave:  the timer controller; it takes the controls and drives the status.
interface interval_timer_ctrl_if #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
);
  logic               start;
  logic               stop;
  logic               hold;
  logic               mode_periodic;
  logic [WIDTH-1:0]   period;
  logic [PRESC_W-1:0] prescale;
  logic               irq_ack;

  logic [WIDTH-1:0]   count;
  logic               tick;
  logic               expired;
  logic               irq;
  logic               busy;
  logic [1:0]         state;
  logic               overrun;

  modport master (
    output start, stop, hold, mode_periodic, period, prescale, irq_ack,
    input  count, tick, expired, irq, busy, state, overrun
  );

  modport slave (
    input  start, stop, hold, mode_periodic, period, prescale, irq_ack,
    output count, tick, expired, irq, busy, state, overrun
  );
endinterface

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer controller: one-shot/periodic modes, prescaler,
// pause/resume via hold, abort via stop, sticky interrupt.
// Ports:
//   clk  - rising-edge clock
//   rstn - asynchronous active-low reset
//   bus  - interval_timer_ctrl_if.slave: control inputs (start, stop, hold,
//          mode_periodic, period, prescale, irq_ack) and status outputs
//          (count, tick, expired, irq, busy, state, overrun)
// Build option: define INTERVAL_TIMER_OVERRUN_EN to implement the sticky
// overrun flag; otherwise overrun is tied low.
module interval_timer_ctrl #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  interval_timer_ctrl_if.slave bus
);

  localparam int unsigned NSLICE = WIDTH / 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_inc, p_lat;
  logic [PRESC_W-1:0] presc_q, s_lat;
  logic               mode_lat;
  logic               tick, terminal, term_evt;
  logic               expired_q, irq_q;
  logic               load, clear;
  logic [NSLICE:0]    slice_en;

  // Enable chain across 4-bit slices: slice k advances only when tick is high
  // and every lower slice is all-ones.
  always_comb begin
    slice_en    = '0;
    count_inc   = count_q;
    slice_en[0] = tick;
    for (int unsigned k = 0; k < NSLICE; k++) begin
      slice_en[k+1] = slice_en[k] & (&count_q[4*k +: 4]);
      if (slice_en[k])
        count_inc[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
    end
  end

  assign tick     = (state_q == RUN) && !bus.hold && !bus.stop && (presc_q == s_lat);
  assign terminal = (count_q == p_lat - 1'b1);
  assign term_evt = tick && terminal;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop && (bus.period != '0)) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
          clear   = 1'b1;
        end else if (bus.hold) begin
          state_d = PAUSED;
        end else if (term_evt && !mode_lat) begin
          state_d = IDLE;
        end
      end
      PAUSED: begin
        if (bus.stop) begin
          state_d = IDLE;
          clear   = 1'b1;
        end else if (!bus.hold) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q   <= '0;
      presc_q   <= '0;
      p_lat     <= '0;
      s_lat     <= '0;
      mode_lat  <= 1'b0;
      expired_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      expired_q <= term_evt;
      if (term_evt)         irq_q <= 1'b1;
      else if (bus.irq_ack) irq_q <= 1'b0;

      if (load) begin
        p_lat    <= bus.period;
        s_lat    <= bus.prescale;
        mode_lat <= bus.mode_periodic;
        count_q  <= '0;
        presc_q  <= '0;
      end else if (clear) begin
        count_q <= '0;
        presc_q <= '0;
      end else if (state_q == RUN && !bus.hold) begin
        presc_q <= (presc_q == s_lat) ? '0 : presc_q + 1'b1;
        if (tick)
          count_q <= terminal ? '0 : count_inc;
      end
    end
  end

`ifdef INTERVAL_TIMER_OVERRUN_EN
  logic overrun_q;

  // Set and clear conditions are mutually exclusive on irq_ack.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                             overrun_q <= 1'b0;
    else if (term_evt && irq_q && !bus.irq_ack) overrun_q <= 1'b1;
    else if (bus.irq_ack && !irq_q)        overrun_q <= 1'b0;
  end

  assign bus.overrun = overrun_q;
`else
  assign bus.overrun = 1'b0;
`endif

  assign bus.count   = count_q;
  assign bus.tick    = tick;
  assign bus.expired = expired_q;
  assign bus.irq     = irq_q;
  assign bus.busy    = (state_q == RUN) || (state_q == PAUSED);
  assign bus.state   = state_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Randomized and directed bench for interval_timer_ctrl against a behavioural
// model that tracks the timer with plain integer arithmetic.
module tb_interval_timer_ctrl;

  localparam int WIDTH   = 8;
  localparam int PRESC_W = 4;

  logic clk;
  logic rstn;

  interval_timer_ctrl_if #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) bus ();

  interval_timer_ctrl #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: state 0=idle, 1=run, 2=paused.
  int m_state, m_cnt, m_presc, m_p, m_s;
  bit m_mode, m_exp, m_irq, m_ovr;

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_presc = 0; m_p = 0; m_s = 0;
    m_mode = 0; m_exp = 0; m_irq = 0; m_ovr = 0;
  endtask

  function automatic bit model_tick(input bit hd, input bit sp);
    return (m_state == 1) && !hd && !sp && (m_presc == m_s);
  endfunction

  task automatic model_step(input bit st, input bit sp, input bit hd, input bit md,
                            input int per, input int ps, input bit ack);
    bit tk, term;
    tk   = model_tick(hd, sp);
    term = tk && (m_cnt == m_p - 1);
`ifdef INTERVAL_TIMER_OVERRUN_EN
    if (term && m_irq && !ack) m_ovr = 1;
    else if (ack && !m_irq)    m_ovr = 0;
`endif
    m_exp = term;
    if (term)     m_irq = 1;
    else if (ack) m_irq = 0;
    case (m_state)
      0: if (st && !sp && per != 0) begin
           m_p = per; m_s = ps; m_mode = md;
           m_cnt = 0; m_presc = 0; m_state = 1;
         end
      1: if (sp) begin
           m_state = 0; m_cnt = 0; m_presc = 0;
         end else if (hd) begin
           m_state = 2;
         end else begin
           m_presc = (m_presc == m_s) ? 0 : m_presc + 1;
           if (tk) m_cnt = (m_cnt + 1) % m_p;
           if (term && !m_mode) m_state = 0;
         end
      default: if (sp) begin
           m_state = 0; m_cnt = 0; m_presc = 0;
         end else if (!hd) begin
           m_state = 1;
         end
    endcase
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle(input bit st, input bit sp, input bit hd, input bit md,
                       input int per, input int ps, input bit ack);
    bus.start = st; bus.stop = sp; bus.hold = hd; bus.mode_periodic = md;
    bus.period = per[WIDTH-1:0]; bus.prescale = ps[PRESC_W-1:0]; bus.irq_ack = ack;
    #1;
    check("count",   32'(bus.count),   32'(m_cnt));
    check("state",   32'(bus.state),   32'(m_state));
    check("busy",    32'(bus.busy),    32'(m_state != 0));
    check("tick",    32'(bus.tick),    32'(model_tick(hd, sp)));
    check("expired", 32'(bus.expired), 32'(m_exp));
    check("irq",     32'(bus.irq),     32'(m_irq));
    check("overrun", 32'(bus.overrun), 32'(m_ovr));
    model_step(st, sp, hd, md, per, ps, ack);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit hd);
    for (int i = 0; i < n; i++) cycle(0, 0, hd, 0, 0, 0, 0);
  endtask

  task automatic ack_irq();
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    bus.start = 0; bus.stop = 0; bus.hold = 0; bus.mode_periodic = 0;
    bus.period = '0; bus.prescale = '0; bus.irq_ack = 0;
    rstn = 0;
    model_reset();
    @(negedge clk);
    #1;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_irq",   32'(bus.irq),   32'd0);
    check("rst_exp",   32'(bus.expired), 32'd0);
    @(negedge clk);
    rstn = 1;
    @(negedge clk);

    // One-shot P=5, S=0.
    cycle(1, 0, 0, 0, 5, 0, 0);
    idle(8, 0);
    ack_irq();

    // Periodic P=3, S=1; ack mid-run, irq re-sets on next terminal.
    cycle(1, 0, 0, 1, 3, 1, 0);
    idle(14, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    idle(8, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    ack_irq();

    // Slice carry: P=0x20 periodic through 0x0F->0x10 and 0x1F->0x00.
    cycle(1, 0, 0, 1, 32'h20, 0, 0);
    idle(36, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    ack_irq();

    // Hold at count=2 for 4 cycles.
    cycle(1, 0, 0, 0, 10, 0, 0);
    idle(2, 0);
    idle(4, 1);
    idle(3, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);

    // Stop on the terminal tick, then start with period 0.
    cycle(1, 0, 0, 0, 4, 0, 0);
    idle(3, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    idle(2, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    idle(2, 0);

    // Periodic P=2, no ack: overrun after the second terminal when enabled.
    cycle(1, 0, 0, 1, 2, 0, 0);
    idle(6, 0);
    ack_irq();
    cycle(0, 1, 0, 0, 0, 0, 0);

    // Randomized traffic with one asynchronous reset mid-run.
    for (int i = 0; i < 3000; i++) begin
      bit st, sp, hd, md, ack;
      int per, ps;
      if (i == 1500) begin
        cycle(1, 0, 0, 1, 3, 0, 0);
        idle(2, 0);
        #2 rstn = 0;
        #1;
        check("arst_count", 32'(bus.count),   32'd0);
        check("arst_state", 32'(bus.state),   32'd0);
        check("arst_exp",   32'(bus.expired), 32'd0);
        check("arst_irq",   32'(bus.irq),     32'd0);
        model_reset();
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
      end
      st  = ($urandom_range(0, 7) == 0);
      sp  = ($urandom_range(0, 39) == 0);
      hd  = ($urandom_range(0, 9) == 0);
      md  = $urandom_range(0, 1);
      ack = ($urandom_range(0, 11) == 0);
      per = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 20);
      ps  = $urandom_range(0, 3);
      cycle(st, sp, hd, md, per, ps, ack);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
